// File: rtl/fft_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_seq_pkg : shared types and constants for fft_frame_sequencer   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fft_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONFIG = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } seqState_t;

    localparam logic [3:0] REG_CTRL        = 4'h0;
    localparam logic [3:0] REG_NFFT        = 4'h4;
    localparam logic [3:0] REG_STATUS      = 4'h8;
    localparam logic [3:0] REG_FRAME_COUNT = 4'hC;

    localparam int CTRL_START      = 0;
    localparam int CTRL_FWD_INV    = 1;
    localparam int CTRL_CONTINUOUS = 2;
    localparam int CTRL_STOP       = 3;

    localparam int NFFT_LSB    = 0;
    localparam int NFFT_BITS   = 5;
    localparam int FWD_INV_BIT = 8;

    function automatic logic [31:0] statusWord(input seqState_t st);
        return {28'd0, (st != ST_IDLE), st};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_seq_axil_regs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_seq_axil_regs : AXI4-Lite slave and register file              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fft_seq_axil_regs
    import fft_seq_pkg::*;
#(
    parameter int MAX_LOG2 = 12,
    parameter int MIN_LOG2 = 3
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [3:0]  s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [3:0]  s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  seqState_t   seqState,
    input  logic [31:0] frameCount,
    output logic        startPulse,
    output logic        stopPulse,
    output logic        countClear,
    output logic        fwdInv,
    output logic        continuous,
    output logic [4:0]  nfft
);

    localparam logic [4:0] c_MIN_NFFT = 5'(MIN_LOG2);
    localparam logic [4:0] c_MAX_NFFT = 5'(MAX_LOG2);

    logic        w_wrReq;
    logic        w_wrHs;
    logic        w_rdHs;
    logic [31:0] w_rdMux;
    logic        w_unused;

    assign w_wrReq = s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
    assign w_wrHs  = s_axi_awready && s_axi_wready && s_axi_awvalid && s_axi_wvalid;
    assign w_rdHs  = s_axi_arready && s_axi_arvalid;

    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;
    assign w_unused    = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb[3:1], s_axi_wdata[31:5]};

    always_comb begin
        w_rdMux = '0;
        case ({s_axi_araddr[3:2], 2'b00})
            REG_CTRL: begin
                w_rdMux[CTRL_FWD_INV]    = fwdInv;
                w_rdMux[CTRL_CONTINUOUS] = continuous;
            end
            REG_NFFT:   w_rdMux = {27'd0, nfft};
            REG_STATUS: w_rdMux = statusWord(seqState);
            default:    w_rdMux = frameCount;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            startPulse    <= 1'b0;
            stopPulse     <= 1'b0;
            countClear    <= 1'b0;
            fwdInv        <= 1'b0;
            continuous    <= 1'b0;
            nfft          <= c_MAX_NFFT;
        end else begin
            startPulse <= 1'b0;
            stopPulse  <= 1'b0;
            countClear <= 1'b0;

            // Single-cycle accept strobe; bvalid blocks the next one until the response drains
            s_axi_awready <= w_wrReq && !s_axi_awready;
            s_axi_wready  <= w_wrReq && !s_axi_awready;

            if (w_wrHs) begin
                s_axi_bvalid <= 1'b1;
                if (s_axi_wstrb[0]) begin
                    case ({s_axi_awaddr[3:2], 2'b00})
                        REG_CTRL: begin
                            fwdInv     <= s_axi_wdata[CTRL_FWD_INV];
                            continuous <= s_axi_wdata[CTRL_CONTINUOUS];
                            stopPulse  <= s_axi_wdata[CTRL_STOP];
                            startPulse <= s_axi_wdata[CTRL_START] && !s_axi_wdata[CTRL_STOP];
                        end
                        REG_NFFT: begin
                            if ((s_axi_wdata[4:0] >= c_MIN_NFFT) && (s_axi_wdata[4:0] <= c_MAX_NFFT)) begin
                                nfft <= s_axi_wdata[4:0];
                            end
                        end
                        REG_FRAME_COUNT: countClear <= 1'b1;
                        default: ;
                    endcase
                end
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;

            if (w_rdHs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= w_rdMux;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_frame_sequencer : config/frame sequencer in front of FFT core  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOG2   = 12,
    parameter int MIN_LOG2   = 3,
    parameter int CFG_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [3:0]            s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [3:0]            s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
    output logic                  m_axis_data_tvalid,
    input  logic                  m_axis_data_tready,
    output logic                  m_axis_data_tlast,
    output logic [CFG_WIDTH-1:0]  m_axis_config_tdata,
    output logic                  m_axis_config_tvalid,
    input  logic                  m_axis_config_tready,
    input  logic                  fft_out_tvalid,
    input  logic                  fft_out_tready,
    input  logic                  fft_out_tlast,
    output logic                  irq
);

    localparam logic [MAX_LOG2:0]   c_LEN_ONE = {{MAX_LOG2{1'b0}}, 1'b1};
    localparam logic [MAX_LOG2-1:0] c_CNT_ONE = {{(MAX_LOG2-1){1'b0}}, 1'b1};

    seqState_t             r_state;
    logic [MAX_LOG2-1:0]   r_sampleCnt;
    logic [31:0]           r_frameCount;
    logic [4:0]            r_cfgNfft;
    logic                  r_cfgFwdInv;
    logic                  r_stopLatched;
    logic                  r_cfgValid;
    logic                  r_irq;

    logic                  w_startPulse;
    logic                  w_stopPulse;
    logic                  w_countClear;
    logic                  w_fwdInv;
    logic                  w_continuous;
    logic [4:0]            w_nfft;
    logic                  w_inStream;
    logic                  w_dataHs;
    logic                  w_fftLastHs;
    logic                  w_rearm;
    logic [MAX_LOG2:0]     w_lastIdx;
    logic [CFG_WIDTH-1:0]  w_cfgWord;

    fft_seq_axil_regs #(
        .MAX_LOG2 (MAX_LOG2),
        .MIN_LOG2 (MIN_LOG2)
    ) u_regs (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .seqState      (r_state),
        .frameCount    (r_frameCount),
        .startPulse    (w_startPulse),
        .stopPulse     (w_stopPulse),
        .countClear    (w_countClear),
        .fwdInv        (w_fwdInv),
        .continuous    (w_continuous),
        .nfft          (w_nfft)
    );

    // Sample path is purely combinational so the FFT sees no added latency
    assign w_inStream         = (r_state == ST_STREAM);
    assign m_axis_data_tvalid = w_inStream && s_axis_tvalid;
    assign s_axis_tready      = w_inStream && m_axis_data_tready;
    assign m_axis_data_tdata  = s_axis_tdata;
    assign w_dataHs           = w_inStream && s_axis_tvalid && m_axis_data_tready;
    assign w_lastIdx          = (c_LEN_ONE << r_cfgNfft) - c_LEN_ONE;
    assign m_axis_data_tlast  = w_inStream && ({1'b0, r_sampleCnt} == w_lastIdx);
    assign w_fftLastHs        = fft_out_tvalid && fft_out_tready && fft_out_tlast;
    assign w_rearm            = w_continuous && !r_stopLatched && !w_stopPulse;

    always_comb begin
        w_cfgWord = '0;
        w_cfgWord[NFFT_LSB +: NFFT_BITS] = r_cfgNfft;
        w_cfgWord[FWD_INV_BIT]           = r_cfgFwdInv;
    end

    assign m_axis_config_tdata  = w_cfgWord;
    assign m_axis_config_tvalid = r_cfgValid;
    assign irq                  = r_irq;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state       <= ST_IDLE;
            r_sampleCnt   <= '0;
            r_frameCount  <= '0;
            r_cfgNfft     <= 5'(MAX_LOG2);
            r_cfgFwdInv   <= 1'b0;
            r_stopLatched <= 1'b0;
            r_cfgValid    <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_irq <= 1'b0;

            // A clear landing on the DONE cycle must win over the increment
            if (w_countClear) begin
                r_frameCount <= '0;
            end else if (r_state == ST_DONE) begin
                r_frameCount <= r_frameCount + 32'd1;
            end

            if (w_stopPulse && (r_state != ST_IDLE)) begin
                r_stopLatched <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_startPulse) begin
                        r_state     <= ST_CONFIG;
                        r_cfgNfft   <= w_nfft;
                        r_cfgFwdInv <= w_fwdInv;
                        r_cfgValid  <= 1'b1;
                    end
                end
                ST_CONFIG: begin
                    if (m_axis_config_tready) begin
                        r_cfgValid  <= 1'b0;
                        r_sampleCnt <= '0;
                        r_state     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_dataHs) begin
                        if (m_axis_data_tlast) begin
                            r_sampleCnt <= '0;
                            r_state     <= ST_DRAIN;
                        end else begin
                            r_sampleCnt <= r_sampleCnt + c_CNT_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_fftLastHs) begin
                        r_state <= ST_DONE;
                        r_irq   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_rearm) begin
                        r_state     <= ST_CONFIG;
                        r_cfgNfft   <= w_nfft;
                        r_cfgFwdInv <= w_fwdInv;
                        r_cfgValid  <= 1'b1;
                    end else begin
                        r_state       <= ST_IDLE;
                        r_stopLatched <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fft_frame_sequencer : directed self-checking bench              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fft_frame_sequencer;

    logic        tb_ACLK = 1'b0;
    logic        ARESETN;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_data_tdata;
    logic        m_axis_data_tvalid;
    logic        m_axis_data_tready;
    logic        m_axis_data_tlast;
    logic [15:0] m_axis_config_tdata;
    logic        m_axis_config_tvalid;
    logic        m_axis_config_tready;
    logic        fft_out_tvalid;
    logic        fft_out_tready;
    logic        fft_out_tlast;
    logic        irq;

    int          checks   = 0;
    int          failures = 0;
    int          cfgBeats = 0;
    int          irqCount = 0;
    logic [15:0] lastCfg  = '0;
    logic [31:0] dataQ[$];
    bit          lastQ[$];
    logic [1:0]  lastBresp;

    always #5 tb_ACLK = ~tb_ACLK;

    fft_frame_sequencer #(
        .DATA_WIDTH (32),
        .MAX_LOG2   (12),
        .MIN_LOG2   (3),
        .CFG_WIDTH  (16)
    ) dut (
        .ACLK                 (tb_ACLK),
        .ARESETN              (ARESETN),
        .s_axi_awaddr         (s_axi_awaddr),
        .s_axi_awvalid        (s_axi_awvalid),
        .s_axi_awready        (s_axi_awready),
        .s_axi_wdata          (s_axi_wdata),
        .s_axi_wstrb          (s_axi_wstrb),
        .s_axi_wvalid         (s_axi_wvalid),
        .s_axi_wready         (s_axi_wready),
        .s_axi_bresp          (s_axi_bresp),
        .s_axi_bvalid         (s_axi_bvalid),
        .s_axi_bready         (s_axi_bready),
        .s_axi_araddr         (s_axi_araddr),
        .s_axi_arvalid        (s_axi_arvalid),
        .s_axi_arready        (s_axi_arready),
        .s_axi_rdata          (s_axi_rdata),
        .s_axi_rresp          (s_axi_rresp),
        .s_axi_rvalid         (s_axi_rvalid),
        .s_axi_rready         (s_axi_rready),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tready        (s_axis_tready),
        .m_axis_data_tdata    (m_axis_data_tdata),
        .m_axis_data_tvalid   (m_axis_data_tvalid),
        .m_axis_data_tready   (m_axis_data_tready),
        .m_axis_data_tlast    (m_axis_data_tlast),
        .m_axis_config_tdata  (m_axis_config_tdata),
        .m_axis_config_tvalid (m_axis_config_tvalid),
        .m_axis_config_tready (m_axis_config_tready),
        .fft_out_tvalid       (fft_out_tvalid),
        .fft_out_tready       (fft_out_tready),
        .fft_out_tlast        (fft_out_tlast),
        .irq                  (irq)
    );

    // Handshakes sampled mid-cycle; they complete on the following rising edge
    always @(negedge tb_ACLK) begin
        if (m_axis_config_tvalid && m_axis_config_tready) begin
            cfgBeats <= cfgBeats + 1;
            lastCfg  <= m_axis_config_tdata;
        end
        if (m_axis_data_tvalid && m_axis_data_tready) begin
            dataQ.push_back(m_axis_data_tdata);
            lastQ.push_back(m_axis_data_tlast);
        end
        if (irq) irqCount <= irqCount + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(posedge tb_ACLK); #1;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        do begin @(negedge tb_ACLK); n++; end while (!s_axi_awready && n < 50);
        if (!s_axi_awready) begin
            checks++; failures++;
            $display("FAIL axi_write_timeout: awready=%b required 1", s_axi_awready);
        end
        @(posedge tb_ACLK); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        n = 0;
        do begin @(negedge tb_ACLK); n++; end while (!s_axi_bvalid && n < 50);
        if (!s_axi_bvalid) begin
            checks++; failures++;
            $display("FAIL axi_bvalid_timeout: bvalid=%b required 1", s_axi_bvalid);
        end
        lastBresp = s_axi_bresp;
        @(posedge tb_ACLK); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axiRead(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(posedge tb_ACLK); #1;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge tb_ACLK); n++; end while (!s_axi_arready && n < 50);
        if (!s_axi_arready) begin
            checks++; failures++;
            $display("FAIL axi_read_timeout: arready=%b required 1", s_axi_arready);
        end
        @(posedge tb_ACLK); #1;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        n = 0;
        do begin @(negedge tb_ACLK); n++; end while (!s_axi_rvalid && n < 50);
        if (!s_axi_rvalid) begin
            checks++; failures++;
            $display("FAIL axi_rvalid_timeout: rvalid=%b required 1", s_axi_rvalid);
        end
        data = s_axi_rdata; resp = s_axi_rresp;
        @(posedge tb_ACLK); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic streamSamples(input int n, input logic [31:0] base, input bit gaps);
        int sent = 0;
        int cyc  = 0;
        bit pend = 0;
        while (sent < n && cyc < 3000) begin
            @(posedge tb_ACLK); #1;
            if (!pend) s_axis_tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axis_tdata       = base + 32'(sent);
            m_axis_data_tready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge tb_ACLK);
            if (s_axis_tvalid && s_axis_tready) begin sent++; pend = 0; end
            else pend = s_axis_tvalid;
            cyc++;
        end
        @(posedge tb_ACLK); #1;
        s_axis_tvalid = 1'b0; m_axis_data_tready = 1'b1;
        if (sent < n) begin
            checks++; failures++;
            $display("FAIL stream_timeout: sent=%0d required %0d", sent, n);
        end
    endtask

    task automatic fftReturn;
        @(posedge tb_ACLK); #1;
        fft_out_tvalid = 1'b1; fft_out_tready = 1'b1; fft_out_tlast = 1'b1;
        @(posedge tb_ACLK); #1;
        fft_out_tvalid = 1'b0; fft_out_tready = 1'b0; fft_out_tlast = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d; logic [1:0] r;
        logic [31:0] expRegs [4];
        expRegs[0] = 32'h0; expRegs[1] = 32'hC; expRegs[2] = 32'h0; expRegs[3] = 32'h0;
        repeat (3) @(negedge tb_ACLK);
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
             s_axis_tready, m_axis_data_tvalid, m_axis_config_tvalid, irq} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 000000000",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
                      s_axis_tready, m_axis_data_tvalid, m_axis_config_tvalid, irq});
        end
        @(posedge tb_ACLK); #1;
        ARESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            axiRead(4'(i * 4), d, r);
            checks++;
            if (d !== expRegs[i] || r !== 2'b00) begin
                failures++;
                $display("FAIL reset_reg%0d: got %h resp %b required %h resp 00", i, d, r, expRegs[i]);
            end
        end
    endtask

    task automatic test_single_frame;
        logic [31:0] d; logic [1:0] r;
        int q0, c0, i0, errs;
        q0 = dataQ.size(); c0 = cfgBeats; i0 = irqCount;
        axiWrite(4'h4, 32'd3, 4'hF);
        checks++;
        if (lastBresp !== 2'b00) begin failures++; $display("FAIL bresp: got %b required 00", lastBresp); end
        axiWrite(4'h0, 32'h3, 4'hF);
        streamSamples(8, 32'h1, 1'b0);
        checks++;
        if (cfgBeats - c0 != 1 || lastCfg !== 16'h0103) begin
            failures++;
            $display("FAIL single_cfg: beats %0d word %h required 1 word 0103", cfgBeats - c0, lastCfg);
        end
        errs = 0;
        for (int k = 0; k < 8; k++)
            if (q0 + k >= dataQ.size() || dataQ[q0+k] !== 32'(k + 1) || lastQ[q0+k] != (k == 7)) errs++;
        checks++;
        if (dataQ.size() - q0 != 8 || errs != 0) begin
            failures++;
            $display("FAIL single_data: count %0d bad %0d required 8 bad 0", dataQ.size() - q0, errs);
        end
        fftReturn();
        repeat (2) @(posedge tb_ACLK);
        checks++;
        if (irqCount - i0 != 1) begin failures++; $display("FAIL single_irq: got %0d required 1", irqCount - i0); end
        axiRead(4'hC, d, r);
        checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL single_count: got %h required 1", d); end
        axiRead(4'h8, d, r);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL single_status: got %h required 0", d); end
        axiRead(4'h0, d, r);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL ctrl_readback: got %h required 2", d); end
    endtask

    task automatic test_nfft_range;
        logic [31:0] d; logic [1:0] r;
        axiWrite(4'h4, 32'd2, 4'hF);
        axiRead(4'h4, d, r);
        checks++;
        if (d !== 32'd3) begin failures++; $display("FAIL nfft_below_min: got %h required 3", d); end
        axiWrite(4'h4, 32'd13, 4'hF);
        axiRead(4'h4, d, r);
        checks++;
        if (d !== 32'd3) begin failures++; $display("FAIL nfft_above_max: got %h required 3", d); end
        axiWrite(4'h4, 32'd5, 4'h0);
        axiRead(4'h4, d, r);
        checks++;
        if (d !== 32'd3) begin failures++; $display("FAIL nfft_wstrb0: got %h required 3", d); end
        axiWrite(4'h4, 32'd12, 4'h1);
        axiRead(4'h4, d, r);
        checks++;
        if (d !== 32'd12) begin failures++; $display("FAIL nfft_max: got %h required c", d); end
        axiWrite(4'h4, 32'd3, 4'h1);
    endtask

    task automatic test_continuous_stop;
        logic [31:0] d; logic [1:0] r;
        int q0, c0, i0, errs;
        axiWrite(4'hC, 32'h0, 4'hF);
        q0 = dataQ.size(); c0 = cfgBeats; i0 = irqCount;
        axiWrite(4'h0, 32'h5, 4'hF);
        for (int f = 0; f < 3; f++) begin
            streamSamples(8, 32'(1 + 8 * f), 1'b1);
            fftReturn();
        end
        repeat (2) @(posedge tb_ACLK);
        errs = 0;
        for (int k = 0; k < 24; k++)
            if (q0 + k >= dataQ.size() || dataQ[q0+k] !== 32'(k + 1) || lastQ[q0+k] != ((k % 8) == 7)) errs++;
        checks++;
        if (dataQ.size() - q0 != 24 || errs != 0) begin
            failures++;
            $display("FAIL cont_data: count %0d bad %0d required 24 bad 0", dataQ.size() - q0, errs);
        end
        // Three frames plus the already re-armed fourth frame
        checks++;
        if (cfgBeats - c0 != 4 || lastCfg !== 16'h0003) begin
            failures++;
            $display("FAIL cont_cfg: beats %0d word %h required 4 word 0003", cfgBeats - c0, lastCfg);
        end
        axiRead(4'hC, d, r);
        checks++;
        if (d !== 32'd3) begin failures++; $display("FAIL cont_count: got %h required 3", d); end
        axiWrite(4'h0, 32'hC, 4'hF);
        streamSamples(8, 32'd25, 1'b0);
        fftReturn();
        repeat (4) @(posedge tb_ACLK);
        checks++;
        if (cfgBeats - c0 != 4 || irqCount - i0 != 4) begin
            failures++;
            $display("FAIL stop_cfg: beats %0d irqs %0d required 4 and 4", cfgBeats - c0, irqCount - i0);
        end
        axiRead(4'h8, d, r);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL stop_status: got %h required 0", d); end
        axiRead(4'hC, d, r);
        checks++;
        if (d !== 32'd4) begin failures++; $display("FAIL stop_count: got %h required 4", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d; logic [1:0] r;
        int q0, c0, i0, errs, n;
        bit sawReady;
        q0 = dataQ.size(); c0 = cfgBeats; i0 = irqCount;
        axiWrite(4'h0, 32'h1, 4'hF);
        streamSamples(3, 32'h100, 1'b0);
        axiWrite(4'h0, 32'h1, 4'hF);
        streamSamples(5, 32'h103, 1'b0);
        fftReturn();
        repeat (3) @(posedge tb_ACLK);
        errs = 0;
        for (int k = 0; k < 8; k++)
            if (q0 + k >= dataQ.size() || dataQ[q0+k] !== 32'h100 + 32'(k) || lastQ[q0+k] != (k == 7)) errs++;
        checks++;
        if (cfgBeats - c0 != 1 || dataQ.size() - q0 != 8 || errs != 0) begin
            failures++;
            $display("FAIL start_busy: beats %0d count %0d bad %0d required 1 8 0",
                     cfgBeats - c0, dataQ.size() - q0, errs);
        end
        axiRead(4'hC, d, r);
        checks++;
        if (d !== 32'd5) begin failures++; $display("FAIL start_busy_count: got %h required 5", d); end

        i0 = irqCount;
        axiWrite(4'h0, 32'h1, 4'hF);
        streamSamples(8, 32'h180, 1'b0);
        // Align the count-clear write handshake with the DRAIN->DONE edge
        @(posedge tb_ACLK); #1;
        s_axi_awaddr = 4'hC; s_axi_wdata = 32'h0; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(posedge tb_ACLK); #1;
        fft_out_tvalid = 1'b1; fft_out_tready = 1'b1; fft_out_tlast = 1'b1;
        @(negedge tb_ACLK);
        sawReady = s_axi_awready;
        @(posedge tb_ACLK); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        fft_out_tvalid = 1'b0; fft_out_tready = 1'b0; fft_out_tlast = 1'b0;
        n = 0;
        do begin @(negedge tb_ACLK); n++; end while (!s_axi_bvalid && n < 50);
        @(posedge tb_ACLK); #1;
        s_axi_bready = 1'b0;
        repeat (2) @(posedge tb_ACLK);
        checks++;
        if (!sawReady || irqCount - i0 != 1) begin
            failures++;
            $display("FAIL clear_align: awready %b irqs %0d required 1 and 1", sawReady, irqCount - i0);
        end
        axiRead(4'hC, d, r);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL clear_in_done: got %h required 0", d); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] d; logic [1:0] r;
        int q0, c0, i0, errs;
        axiWrite(4'h0, 32'h1, 4'hF);
        streamSamples(5, 32'h200, 1'b0);
        @(posedge tb_ACLK); #1;
        s_axis_tvalid = 1'b1; m_axis_data_tready = 1'b1;
        #1;
        checks++;
        if (m_axis_data_tvalid !== 1'b1) begin
            failures++; $display("FAIL midframe_active: tvalid %b required 1", m_axis_data_tvalid);
        end
        #1 ARESETN = 1'b0;
        #1;
        checks++;
        if ({m_axis_data_tvalid, s_axis_tready, m_axis_config_tvalid, irq} !== 4'b0) begin
            failures++;
            $display("FAIL async_reset: got %b required 0000",
                     {m_axis_data_tvalid, s_axis_tready, m_axis_config_tvalid, irq});
        end
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge tb_ACLK);
        #1 ARESETN = 1'b1;
        axiRead(4'h4, d, r);
        checks++;
        if (d !== 32'd12) begin failures++; $display("FAIL post_reset_nfft: got %h required c", d); end
        q0 = dataQ.size(); c0 = cfgBeats; i0 = irqCount;
        axiWrite(4'h4, 32'd3, 4'hF);
        axiWrite(4'h0, 32'h1, 4'hF);
        streamSamples(8, 32'h300, 1'b0);
        fftReturn();
        repeat (2) @(posedge tb_ACLK);
        errs = 0;
        for (int k = 0; k < 8; k++)
            if (q0 + k >= dataQ.size() || dataQ[q0+k] !== 32'h300 + 32'(k) || lastQ[q0+k] != (k == 7)) errs++;
        checks++;
        if (cfgBeats - c0 != 1 || lastCfg !== 16'h0003 || dataQ.size() - q0 != 8 || errs != 0 || irqCount - i0 != 1) begin
            failures++;
            $display("FAIL post_reset_frame: beats %0d word %h count %0d bad %0d irqs %0d required 1 0003 8 0 1",
                     cfgBeats - c0, lastCfg, dataQ.size() - q0, errs, irqCount - i0);
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
        m_axis_data_tready = 1'b1; m_axis_config_tready = 1'b1;
        fft_out_tvalid = 1'b0; fft_out_tready = 1'b0; fft_out_tlast = 1'b0;

        test_reset();
        test_single_frame();
        test_nfft_range();
        test_continuous_stop();
        test_back_to_back();
        test_reset_midframe();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
